// File: rtl/rc4_key_search_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rc4_seq_pkg
// Description : Shared types and constants for the RC4 key-search sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rc4_seq_pkg;

    localparam int c_KEY_WIDTH_DEFAULT = 24;

    // Output vector bit positions; the state encoding carries this vector
    // in its low bits so every output is a direct flop tap.
    localparam int c_OB_RESET_MEM = 0;
    localparam int c_OB_S_RAM     = 1;
    localparam int c_OB_SHUFFLE   = 2;
    localparam int c_OB_DECRYPT   = 3;
    localparam int c_OB_CHECK     = 4;
    localparam int c_OB_BUSY      = 5;
    localparam int c_OB_FOUND     = 6;
    localparam int c_OB_EXHAUSTED = 7;

    localparam int c_OUT_W   = 8;
    localparam int c_IDX_W   = 4;
    localparam int c_STATE_W = c_IDX_W + c_OUT_W;

    typedef enum logic [c_STATE_W-1:0] {
        ST_RESTART     = {4'd0, 8'b0000_0001},
        ST_IDLE        = {4'd1, 8'b0000_0000},
        ST_RESTART_MEM = {4'd2, 8'b0010_0001},
        ST_INIT_S      = {4'd3, 8'b0010_0010},
        ST_SHUFFLE     = {4'd4, 8'b0010_0100},
        ST_DECRYPT     = {4'd5, 8'b0010_1000},
        ST_CHECK       = {4'd6, 8'b0011_0000},
        ST_NEXT_KEY    = {4'd7, 8'b0010_0000},
        ST_FOUND       = {4'd8, 8'b0100_0000},
        ST_EXHAUSTED   = {4'd9, 8'b1000_0000}
    } state_e;

    function automatic logic [c_OUT_W-1:0] state_outputs(input state_e s);
        return s[c_OUT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_key_search_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_search_sequencer_if
// Description : Phase start/finish handshake bundle between sequencer and core.
// Revision    : 1.0 - initial release
// ============================================================================
interface rc4_key_search_sequencer_if;
    import rc4_seq_pkg::*;

    logic s_ram_reset_start;
    logic s_ram_reset_finish;
    logic shuffle_array_start;
    logic shuffle_array_finish;
    logic decrypt_message_start;
    logic decrypt_message_finish;
    logic d_ram_check_start;
    logic d_ram_check_finish;
    logic d_ram_check_valid;
    logic reset_mem_access_controller;

    modport master (
        output s_ram_reset_start,
        output shuffle_array_start,
        output decrypt_message_start,
        output d_ram_check_start,
        output reset_mem_access_controller,
        input  s_ram_reset_finish,
        input  shuffle_array_finish,
        input  decrypt_message_finish,
        input  d_ram_check_finish,
        input  d_ram_check_valid
    );

    modport slave (
        input  s_ram_reset_start,
        input  shuffle_array_start,
        input  decrypt_message_start,
        input  d_ram_check_start,
        input  reset_mem_access_controller,
        output s_ram_reset_finish,
        output shuffle_array_finish,
        output decrypt_message_finish,
        output d_ram_check_finish,
        output d_ram_check_valid
    );
endinterface
`default_nettype wire

// File: rtl/rc4_key_search_sequencer_key_stepper.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_stepper
// Description : Key register with range check and saturating attempt counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_stepper
    import rc4_seq_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = c_KEY_WIDTH_DEFAULT,
    parameter int unsigned KEY_START = 0,
    parameter int unsigned KEY_STEP  = 1,
    parameter int unsigned KEY_LAST  = 2**22 - 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 load_start,
    input  wire logic                 step,
    input  wire logic                 count,
    output logic [KEY_WIDTH-1:0]      key,
    output logic [KEY_WIDTH-1:0]      keys_tried,
    output logic                      last
);

    localparam logic [KEY_WIDTH-1:0] c_START = KEY_WIDTH'(KEY_START);
    localparam logic [KEY_WIDTH:0]   c_STEP  = (KEY_WIDTH + 1)'(KEY_STEP);
    localparam logic [KEY_WIDTH:0]   c_LAST  = (KEY_WIDTH + 1)'(KEY_LAST);

    logic [KEY_WIDTH-1:0] r_key_q;
    logic [KEY_WIDTH-1:0] w_key_d;
    logic [KEY_WIDTH-1:0] r_tried_q;
    logic [KEY_WIDTH-1:0] w_tried_d;
    logic [KEY_WIDTH:0]   w_sum;
    logic                 w_last;

    // The extra sum bit keeps a wrap past 2**KEY_WIDTH from looking in range.
    always_comb begin
        w_sum     = {1'b0, r_key_q} + c_STEP;
        w_last    = (w_sum > c_LAST);
        w_key_d   = r_key_q;
        w_tried_d = r_tried_q;
        if (load_start) begin
            w_key_d   = c_START;
            w_tried_d = '0;
        end else begin
            if (step && !w_last) begin
                w_key_d = w_sum[KEY_WIDTH-1:0];
            end
            if (count && (r_tried_q != {KEY_WIDTH{1'b1}})) begin
                w_tried_d = r_tried_q + KEY_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_q   <= c_START;
            r_tried_q <= '0;
        end else begin
            r_key_q   <= w_key_d;
            r_tried_q <= w_tried_d;
        end
    end

    assign key        = r_key_q;
    assign keys_tried = r_tried_q;
    assign last       = w_last;

endmodule
`default_nettype wire

// File: rtl/rc4_key_search_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rc4_key_search_sequencer
// Description : Per-core phase sequencer iterating keys over a strided range.
// Revision    : 1.0 - initial release
// ============================================================================
module rc4_key_search_sequencer
    import rc4_seq_pkg::*;
#(
    parameter int unsigned KEY_WIDTH = c_KEY_WIDTH_DEFAULT,
    parameter int unsigned KEY_START = 0,
    parameter int unsigned KEY_STEP  = 1,
    parameter int unsigned KEY_LAST  = 2**22 - 1
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    input  wire logic                    start,
    input  wire logic                    abort,
    rc4_key_search_sequencer_if.master   bus,
    output logic [KEY_WIDTH-1:0]         key,
    output logic [KEY_WIDTH-1:0]         keys_tried,
    output logic                         busy,
    output logic                         found,
    output logic                         exhausted
);

    state_e               r_state_q;
    state_e               w_state_d;
    logic                 w_load_start;
    logic                 w_step;
    logic                 w_count;
    logic                 w_last;
    logic [c_OUT_W-1:0]   w_out;

    rc4_key_stepper #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_START (KEY_START),
        .KEY_STEP  (KEY_STEP),
        .KEY_LAST  (KEY_LAST)
    ) u_key_stepper (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_start (w_load_start),
        .step       (w_step),
        .count      (w_count),
        .key        (key),
        .keys_tried (keys_tried),
        .last       (w_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q <= ST_RESTART;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // abort is tested ahead of every finish so it wins a same-cycle race.
    always_comb begin
        w_state_d = r_state_q;
        w_step    = 1'b0;
        w_count   = 1'b0;
        case (r_state_q)
            ST_RESTART: begin
                w_state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    w_state_d = ST_RESTART_MEM;
                end
            end
            ST_RESTART_MEM: begin
                w_state_d = abort ? ST_RESTART : ST_INIT_S;
            end
            ST_INIT_S: begin
                if (abort) begin
                    w_state_d = ST_RESTART;
                end else if (bus.s_ram_reset_finish) begin
                    w_state_d = ST_SHUFFLE;
                end
            end
            ST_SHUFFLE: begin
                if (abort) begin
                    w_state_d = ST_RESTART;
                end else if (bus.shuffle_array_finish) begin
                    w_state_d = ST_DECRYPT;
                end
            end
            ST_DECRYPT: begin
                if (abort) begin
                    w_state_d = ST_RESTART;
                end else if (bus.decrypt_message_finish) begin
                    w_state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    w_state_d = ST_RESTART;
                end else if (bus.d_ram_check_finish) begin
                    w_count   = 1'b1;
                    w_state_d = bus.d_ram_check_valid ? ST_FOUND : ST_NEXT_KEY;
                end
            end
            ST_NEXT_KEY: begin
                if (abort) begin
                    w_state_d = ST_RESTART;
                end else if (w_last) begin
                    w_state_d = ST_EXHAUSTED;
                end else begin
                    w_step    = 1'b1;
                    w_state_d = ST_RESTART_MEM;
                end
            end
            ST_FOUND, ST_EXHAUSTED: begin
                if (abort) begin
                    w_state_d = ST_RESTART;
                end else if (!start) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_RESTART;
            end
        endcase
        // Loading on entry means key/keys_tried already read back as the
        // start values during the first IDLE cycle.
        w_load_start = (w_state_d == ST_IDLE);
    end

    assign w_out = state_outputs(r_state_q);

    assign bus.reset_mem_access_controller = w_out[c_OB_RESET_MEM];
    assign bus.s_ram_reset_start           = w_out[c_OB_S_RAM];
    assign bus.shuffle_array_start         = w_out[c_OB_SHUFFLE];
    assign bus.decrypt_message_start       = w_out[c_OB_DECRYPT];
    assign bus.d_ram_check_start           = w_out[c_OB_CHECK];
    assign busy                            = w_out[c_OB_BUSY];
    assign found                           = w_out[c_OB_FOUND];
    assign exhausted                       = w_out[c_OB_EXHAUSTED];

endmodule
`default_nettype wire

// File: doc/rc4_key_search_sequencer.md
# rc4_key_search_sequencer

Per-core control sequencer for the RC4 key-search decoder. It drives one core's four processing phases (S-RAM init, array shuffle, message decrypt, D-RAM validity check) through level start/finish handshakes. Unlike the single-pass core controller, it iterates keys itself: it steps a key counter across a parametrised range, restarts the pipeline for each key, and stops on a valid decrypt or when the range is exhausted. It also supports a global abort, so a multi-core top level can stop every core once one core finds the key.

## Interface
- KEY_WIDTH, 24, width of key counter and key output
- KEY_START, 0, first key tried by this core (multi-core offset)
- KEY_STEP, 1, key increment between attempts (= core count for interleaved search)
- KEY_LAST, 2**22-1, highest key allowed; no key above it is ever presented
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  level; begin search when sampled high in IDLE
- abort  in  1  level; terminate search from any busy state
- s_ram_reset_start / s_ram_reset_finish  out/in  1/1  phase 1 handshake
- shuffle_array_start / shuffle_array_finish  out/in  1/1  phase 2 handshake
- decrypt_message_start / decrypt_message_finish  out/in  1/1  phase 3 handshake
- d_ram_check_start / d_ram_check_finish  out/in  1/1  phase 4 handshake
- d_ram_check_valid  in  1  check result, sampled only with d_ram_check_finish
- reset_mem_access_controller  out  1  one-cycle pulse before every key attempt
- key  out  KEY_WIDTH  key currently under test / found key
- keys_tried  out  KEY_WIDTH  count of completed attempts
- busy  out  1  high in any phase or RESTART_MEM state
- found  out  1  high in FOUND
- exhausted  out  1  high in EXHAUSTED

## Operation
- States: RESTART, IDLE, RESTART_MEM, INIT_S, SHUFFLE, DECRYPT, CHECK, NEXT_KEY, FOUND, EXHAUSTED.
- All handshake outputs and status flags are decoded from the state register. They are glitch-free and registered.
- RESTART: reset_mem_access_controller=1 for one cycle, then go to IDLE.
- IDLE: key=KEY_START, keys_tried=0. When start=1, go to RESTART_MEM.
- RESTART_MEM: reset_mem_access_controller=1 for one cycle, then go to INIT_S.
- Phase states: INIT_S asserts s_ram_reset_start, SHUFFLE asserts shuffle_array_start, DECRYPT asserts decrypt_message_start, CHECK asserts d_ram_check_start.
- Each start output is held high until its own finish is sampled high; the sequencer then moves to the next phase.
- A finish input is ignored in every state except its own phase state.
- CHECK with finish=1:
  - valid=1: go to FOUND; key is frozen and keys_tried increments.
  - valid=0: go to NEXT_KEY; keys_tried increments.
- NEXT_KEY:
  - Compute key+KEY_STEP at KEY_WIDTH+1 bits.
  - If the sum > KEY_LAST, go to EXHAUSTED; key holds the last key tried.
  - Otherwise key takes the sum and the sequencer goes to RESTART_MEM.
- FOUND / EXHAUSTED: hold while start=1. When start=0, go to IDLE.
- abort=1 in any busy state, or in FOUND/EXHAUSTED, forces RESTART on the next edge. key and keys_tried are cleared in IDLE.
- abort has priority over every finish input in the same cycle.
- Illegal state encoding: go to RESTART.
- keys_tried saturates at all-ones; it never wraps.

## Timing
- Reset (asynchronous assert, synchronous deassert at system level): state=RESTART, key=KEY_START, keys_tried=0.
  - While reset_n=0: reset_mem_access_controller=1, all other outputs 0.
- Phase start outputs:
  - Start sampled in IDLE at edge N: reset_mem_access_controller=1 in cycle N+1, s_ram_reset_start=1 from N+2.
  - Finish sampled high at edge M: the current phase start drops and the next phase start rises, both from M+1. There is no gap cycle.
- Key transitions:
  - Per-key overhead is 3 cycles beyond the phase latencies: CHECK→NEXT_KEY, NEXT_KEY→RESTART_MEM, RESTART_MEM→INIT_S.
  - key updates at the NEXT_KEY→RESTART_MEM edge, so it is stable for the entire attempt.
- Status outputs:
  - found/exhausted rise one cycle after the deciding edge.
  - busy falls in the same cycle that found or exhausted rises.
- A finish held high across a phase change is not reused; each phase needs its own finish sampled in its own state.
- Asynchronous reset mid-attempt returns to RESTART immediately. Sub-blocks rely on reset_mem_access_controller to recover.

## Structure
- Package rc4_seq_pkg holds:
  - the state enum, with an explicit encoding: the low bits are the one-hot output vector and the high bits the state index;
  - KEY_WIDTH default constant;
  - output-bit index localparams.
- Sub-module rc4_key_stepper holds the key register, the KEY_WIDTH+1 adder, the KEY_LAST comparison, and the keys_tried saturating counter. Its ports are clk, reset_n, load_start, step, and outputs key, keys_tried, last.
- Top module holds the state register and the next-state logic only.

## Test plan
- Reset, then start=1 with KEY_START=0, and each sub-block answers finish after 2 cycles; check valid=1 on the first key -> found=1, key=0, keys_tried=1, and the phase starts rise in order 1,2,3,4 with no overlap.
- KEY_START=1, KEY_STEP=4, KEY_LAST=20, valid returned only for key 13 -> keys tried are exactly 1,5,9,13; found=1, keys_tried=4.
- KEY_LAST=9, KEY_STEP=4, KEY_START=1, never valid -> EXHAUSTED after keys 1,5,9; key=9, exhausted=1, no key 13 presented.
- abort asserted mid-DECRYPT in the same cycle as decrypt_message_finish -> RESTART next cycle, then IDLE, key=KEY_START; d_ram_check_start never rises.
- Stray shuffle_array_finish pulses during INIT_S and during IDLE -> no state change.
- In FOUND, start held high for 10 cycles then dropped -> found held for all 10 cycles, IDLE one cycle after start=0.
- reset_n pulsed low mid-SHUFFLE -> outputs go to reset values immediately.
